fifo_buffer: RTL

FIFO_BUFFER -- requirements
Module: fifo_buffer

---
 rtl/fifo_buffer_pkg.sv | 30 +++
 rtl/fifo_buffer_mem.sv | 39 +++
 rtl/fifo_buffer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/fifo_buffer_pkg.sv
// ---------------------------------------------------------------------------
// fifo_buffer_pkg
// Shared actor definitions for the dataflow actor modules.
// Holds the default token width, the actor status codes used across the
// actor library and a small pointer-wrap helper used by the FIFO control.
// No ports (package).
// ---------------------------------------------------------------------------
package fifo_buffer_pkg;

   // Default token width shared by every actor in the library
   localparam int ACTOR_DATA_WIDTH = 8;

   // Status codes reported by actors to their neighbours
   typedef enum logic [1:0] {
      ACTOR_OK    = 2'd0,
      ACTOR_FULL  = 2'd1,
      ACTOR_EMPTY = 2'd2,
      ACTOR_ERROR = 2'd3
   } actorStatus_t;

   // Circular-pointer increment: wraps from size-1 back to zero, so the
   // buffer capacity does not have to be a power of two
   function automatic int wrapIncrement(input int ptr, input int size);
      if (ptr == size - 1) begin
         return 0;
      end
      return ptr + 1;
   endfunction

endpackage

// File: rtl/fifo_buffer_mem.sv
// ---------------------------------------------------------------------------
// fifo_mem
// Token storage for fifo_buffer: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
// Ports:
//   clock       rising-edge clock for the write port
//   writeEnable store writeData at writeAddr on the rising edge
//   writeAddr   write location
//   writeData   token to store
//   readAddr    read location
//   readData    token at readAddr (combinational)
// ---------------------------------------------------------------------------
module fifo_mem #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clock,
   input  logic                  writeEnable,
   input  logic [ADDR_WIDTH-1:0] writeAddr,
   input  logic [DATA_WIDTH-1:0] writeData,
   input  logic [ADDR_WIDTH-1:0] readAddr,
   output logic [DATA_WIDTH-1:0] readData
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   // Write port: storage has no reset, so stale tokens simply get
   // overwritten as the write pointer comes round again
   always_ff @(posedge clock) begin
      if (writeEnable) begin
         r_mem[writeAddr] <= writeData;
      end
   end

   // Asynchronous read port gives first-word-fall-through at the head
   assign readData = r_mem[readAddr];

endmodule

// File: rtl/fifo_buffer.sv
// ---------------------------------------------------------------------------
// fifo_buffer
// First-word-fall-through FIFO between a producer and a consumer actor.
// All control (pointers, population, flags) lives here; storage is fifo_mem.
// Ports:
//   clock       rising-edge system clock
//   reset       asynchronous, active-high reset
//   in          token from the producer
//   write       producer push request
//   read        consumer pop request
//   out         head token (valid while empty is low)
//   full        population equals BUFFER_SIZE
//   empty       population equals zero
//   population  current token count
//   overflow    sticky: a write was rejected
//   underflow   sticky: a read was rejected
// ---------------------------------------------------------------------------
module fifo_buffer
   import fifo_buffer_pkg::*;
#(
   parameter int DATA_WIDTH        = ACTOR_DATA_WIDTH,
   parameter int BUFFER_SIZE       = 16,
   parameter int BUFFER_SIZE_WIDTH = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic [DATA_WIDTH-1:0]        in,
   input  logic                         write,
   input  logic                         read,
   output logic [DATA_WIDTH-1:0]        out,
   output logic                         full,
   output logic                         empty,
   output logic [BUFFER_SIZE_WIDTH:0]   population,
   output logic                         overflow,
   output logic                         underflow
);

   localparam logic [BUFFER_SIZE_WIDTH:0] FULL_COUNT = (BUFFER_SIZE_WIDTH+1)'(BUFFER_SIZE);

   logic [BUFFER_SIZE_WIDTH-1:0] r_wrPtr;
   logic [BUFFER_SIZE_WIDTH-1:0] r_rdPtr;
   logic [BUFFER_SIZE_WIDTH:0]   r_population;
   logic                         r_full;
   logic                         r_empty;
   logic                         r_overflow;
   logic                         r_underflow;

   logic                         w_pushOk;
   logic                         w_popOk;
   logic [BUFFER_SIZE_WIDTH:0]   w_nextPopulation;
   logic [BUFFER_SIZE_WIDTH-1:0] w_nextWrPtr;
   logic [BUFFER_SIZE_WIDTH-1:0] w_nextRdPtr;

   // A full buffer still accepts a write when a read happens in the same
   // cycle: the head slot being popped is exactly the slot being written,
   // and the async read port still shows the old head until the edge.
   // A full buffer is never empty (capacity >= 2), so that pop is accepted.
   assign w_pushOk = write && (!r_full || read);
   assign w_popOk  = read && !r_empty;

   assign w_nextWrPtr = BUFFER_SIZE_WIDTH'(wrapIncrement(int'(r_wrPtr), BUFFER_SIZE));
   assign w_nextRdPtr = BUFFER_SIZE_WIDTH'(wrapIncrement(int'(r_rdPtr), BUFFER_SIZE));

   // Population only moves when exactly one of push/pop is accepted
   always_comb begin
      w_nextPopulation = r_population;
      if (w_pushOk && !w_popOk) begin
         w_nextPopulation = r_population + 1'b1;
      end else if (!w_pushOk && w_popOk) begin
         w_nextPopulation = r_population - 1'b1;
      end
   end

   // Control state. full/empty are registered from the next population so
   // they only change on a clock edge or reset. Error flags are sticky and
   // only reset clears them.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wrPtr      <= '0;
         r_rdPtr      <= '0;
         r_population <= '0;
         r_full       <= 1'b0;
         r_empty      <= 1'b1;
         r_overflow   <= 1'b0;
         r_underflow  <= 1'b0;
      end else begin
         if (w_pushOk) begin
            r_wrPtr <= w_nextWrPtr;
         end
         if (w_popOk) begin
            r_rdPtr <= w_nextRdPtr;
         end
         r_population <= w_nextPopulation;
         r_full       <= (w_nextPopulation == FULL_COUNT);
         r_empty      <= (w_nextPopulation == '0);
         if (write && r_full && !read) begin
            r_overflow <= 1'b1;
         end
         if (read && r_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   // Token storage; the head token is read combinationally at rd_ptr
   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (BUFFER_SIZE),
      .ADDR_WIDTH (BUFFER_SIZE_WIDTH)
   ) u_mem (
      .clock       (clock),
      .writeEnable (w_pushOk),
      .writeAddr   (r_wrPtr),
      .writeData   (in),
      .readAddr    (r_rdPtr),
      .readData    (out)
   );

   assign full       = r_full;
   assign empty      = r_empty;
   assign population = r_population;
   assign overflow   = r_overflow;
   assign underflow  = r_underflow;

endmodule
